bw_filter: RTL and testbench

BW_FILTER -- requirements
Module: bw_filter

---
 rtl/bw_filter_pkg.sv | 19 +
 rtl/bw_filter_if.sv | 34 +++
 rtl/bw_filter_luma_calc.sv | 34 +++
 rtl/bw_filter.sv | 124 ++++++++++++
 tb/tb_bw_filter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/bw_filter_pkg.sv
// Shared image constants for the capture, filter and display blocks.
// Holds the frame geometry, bus widths and the B/W filter FSM encoding.
package bw_filter_pkg;

  localparam int unsigned IMG_W      = 320;
  localparam int unsigned IMG_H      = 240;
  localparam int unsigned NUM_PIXELS = IMG_W * IMG_H;
  localparam int unsigned ADDR_W     = 17;
  localparam int unsigned PIX_W      = 12;
  localparam int unsigned LUMA_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bw_state_e;

endpackage

// File: rtl/bw_filter_if.sv
// Bus bundle between the main FSM / frame buffers and the B/W filter.
//   start, ack, thresh      : control from the main FSM
//   busy, done, white_count : status back to the main FSM
//   rd_addr / rd_data       : captured-frame buffer read port (1-cycle latency)
//   wr_we / wr_addr/wr_data : B/W image buffer write port
// Modports: master = main FSM / memory side, slave = filter.
interface bw_filter_if #(
  parameter int unsigned ADDR_W = bw_filter_pkg::ADDR_W,
  parameter int unsigned PIX_W  = bw_filter_pkg::PIX_W
);

  logic              start;
  logic              ack;
  logic [3:0]        thresh;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0]  wr_data;
  logic [ADDR_W-1:0] white_count;

  modport master (
    output start, ack, thresh, rd_data,
    input  busy, done, rd_addr, wr_we, wr_addr, wr_data, white_count
  );

  modport slave (
    input  start, ack, thresh, rd_data,
    output busy, done, rd_addr, wr_we, wr_addr, wr_data, white_count
  );

endinterface

// File: rtl/bw_filter_luma_calc.sv
// Combinational luma and threshold stage for one RGB444 pixel.
//   pix_i    : pixel {R[11:8],G[7:4],B[3:0]}
//   thresh_i : latched luma threshold
//   pix_o    : filtered output pixel
//   white_o  : luma >= thresh
// Build option BW_FILTER_GRAY_OUT_EN: pix_o carries {luma,luma,luma}
// instead of the thresholded black/white value; white_o is unaffected.
module luma_calc
  import bw_filter_pkg::*;
(
  input  logic [PIX_W-1:0]  pix_i,
  input  logic [LUMA_W-1:0] thresh_i,
  output logic [PIX_W-1:0]  pix_o,
  output logic              white_o
);

  logic [7:0]        luma_sum;
  logic [LUMA_W-1:0] luma;

  always_comb begin
    // 5R + 9G + 2B peaks at 240, so an 8-bit sum never overflows.
    luma_sum = 8'd5 * {4'd0, pix_i[11:8]}
             + 8'd9 * {4'd0, pix_i[7:4]}
             + 8'd2 * {4'd0, pix_i[3:0]};
    luma     = luma_sum[7:4];
    white_o  = (luma >= thresh_i);
`ifdef BW_FILTER_GRAY_OUT_EN
    pix_o    = {luma, luma, luma};
`else
    pix_o    = white_o ? '1 : '0;
`endif
  end

endmodule

// File: rtl/bw_filter.sv
// Black/white frame filter. On a start request it reads every pixel of the
// captured frame once, converts it to luma, thresholds it and writes the
// result to the B/W buffer at one pixel per clock, then reports done and the
// number of white pixels until the main FSM acknowledges.
//   clk, rst : 25 MHz clock, asynchronous active-high reset
//   bus      : bw_filter_if.slave (start/ack/thresh in, busy/done/
//              white_count out, read and write memory ports)
// Build option BW_FILTER_GRAY_OUT_EN: write gray luma instead of B/W
// (handled in luma_calc).
module bw_filter #(
  parameter int unsigned NUM_PIXELS = bw_filter_pkg::NUM_PIXELS,
  parameter int unsigned ADDR_W     = bw_filter_pkg::ADDR_W,
  parameter int unsigned PIX_W      = bw_filter_pkg::PIX_W
) (
  input logic         clk,
  input logic         rst,
  bw_filter_if.slave  bus
);
  import bw_filter_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  bw_state_e         state_q, state_d;
  logic              issue_q, issue_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [3:0]        thresh_q;

  // Read-data stage: marks which cycle carries valid rd_data and its address.
  logic              rvalid_q;
  logic [ADDR_W-1:0] raddr_q;

  logic              wr_we_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic [ADDR_W-1:0] white_cnt_q;
  logic [ADDR_W-1:0] white_count_q;

  logic [PIX_W-1:0]  pix_out;
  logic              is_white;
  logic              run_entry;
  logic              done_entry;

  luma_calc u_luma_calc (
    .pix_i    (bus.rd_data),
    .thresh_i (thresh_q),
    .pix_o    (pix_out),
    .white_o  (is_white)
  );

  // The first RUN cycle only arms the address issuer, so address 0 goes out
  // one cycle after the start edge. DRAIN ends once the read-data stage is
  // empty, which is the cycle holding the final write.
  always_comb begin
    state_d   = state_q;
    issue_d   = 1'b0;
    rd_addr_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.ack) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!issue_q) begin
          issue_d = 1'b1;
        end else if (rd_addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
        end else begin
          issue_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!rvalid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_entry  = (state_q == ST_IDLE)  && (state_d == ST_RUN);
  assign done_entry = (state_q == ST_DRAIN) && (state_d == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      issue_q       <= 1'b0;
      rd_addr_q     <= '0;
      thresh_q      <= '0;
      rvalid_q      <= 1'b0;
      raddr_q       <= '0;
      wr_we_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      white_cnt_q   <= '0;
      white_count_q <= '0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      rd_addr_q <= rd_addr_d;
      rvalid_q  <= issue_q;
      raddr_q   <= rd_addr_q;
      wr_we_q   <= rvalid_q;
      wr_addr_q <= rvalid_q ? raddr_q : '0;
      wr_data_q <= rvalid_q ? pix_out : '0;
      if (run_entry) begin
        thresh_q    <= bus.thresh;
        white_cnt_q <= '0;
      end else if (rvalid_q && is_white) begin
        white_cnt_q <= white_cnt_q + 1'b1;
      end
      if (done_entry) white_count_q <= white_cnt_q;
    end
  end

  assign bus.busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.rd_addr     = rd_addr_q;
  assign bus.wr_we       = wr_we_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.white_count = white_count_q;

endmodule

// File: tb/tb_bw_filter.sv
// Testbench for bw_filter with a reduced frame size. A registered memory
// model supplies rd_data; expected writes are queued per frame and a
// negedge monitor checks every wr_we against the queue.
// Honours BW_FILTER_GRAY_OUT_EN for the expected pixel value.
module tb_bw_filter;

  localparam int unsigned NP = 200;
  localparam int unsigned AW = 17;
  localparam int unsigned PW = 12;

  typedef struct {
    int          addr;
    logic [11:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] pix_mem [NP];
  exp_t        exp_q [$];
  int          exp_wc;

  bw_filter_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();

  bw_filter #(.NUM_PIXELS(NP), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Frame buffer read port: data one cycle after address.
  always @(posedge clk) begin
    if (int'(bus.rd_addr) < NP) bus.rd_data <= pix_mem[int'(bus.rd_addr)];
    else                        bus.rd_data <= 12'h000;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int luma_of(input logic [11:0] p);
    int r, g, b;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    return (5 * r + 9 * g + 2 * b) / 16;
  endfunction

  function automatic logic [11:0] expect_pix(input logic [11:0] p, input int th);
    logic [3:0] l;
    l = 4'(luma_of(p));
`ifdef BW_FILTER_GRAY_OUT_EN
    return {l, l, l};
`else
    return (int'(l) >= th) ? 12'hFFF : 12'h000;
`endif
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (bus.wr_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, e.addr);
        check("wr_data", bus.wr_data, e.data);
      end
    end
  end

  task automatic load_frame(input int pat, input int th);
    exp_wc = 0;
    for (int i = 0; i < NP; i++) begin
      case (pat)
        0:       pix_mem[i] = 12'hFFF;
        1:       pix_mem[i] = 12'h888;
        2:       pix_mem[i] = (i % 2 == 1) ? 12'hF00 : 12'h00F;
        4:       pix_mem[i] = 12'h0F0;
        default: pix_mem[i] = 12'($urandom);
      endcase
      exp_q.push_back('{addr: i, data: expect_pix(pix_mem[i], th)});
      if (luma_of(pix_mem[i]) >= th) exp_wc++;
    end
  endtask

  task automatic run_frame(input int pat, input int th, input bit drop);
    int cyc, first_we, last_we, done_cyc, bad_addr, bad_busy, bad_hold, bad_done, bad_rs;
    int prev_wc;
    load_frame(pat, th);
    prev_wc = int'(bus.white_count);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ack    = 1'b0;
    bus.thresh = 4'(th);
    @(posedge clk);
    cyc = 0; first_we = -1; last_we = -1; done_cyc = -1;
    bad_addr = 0; bad_busy = 0; bad_hold = 0; bad_done = 0; bad_rs = 0;
    while (done_cyc < 0 && cyc < int'(NP) + 20) begin
      @(negedge clk);
      if (cyc >= 1 && cyc <= int'(NP) && int'(bus.rd_addr) != cyc - 1) bad_addr++;
      if (int'(bus.rd_addr) > int'(NP) - 1) bad_addr++;
      if (cyc <= int'(NP) + 2 && bus.busy !== 1'b1) bad_busy++;
      if (bus.done !== 1'b1 && int'(bus.white_count) != prev_wc) bad_hold++;
      if (bus.wr_we === 1'b1) begin
        if (first_we < 0) first_we = cyc;
        last_we = cyc;
      end
      if (bus.done === 1'b1) done_cyc = cyc;
      if (drop && cyc == 100) begin
        bus.start  = 1'b0;
        bus.thresh = ~4'(th);
      end
      if (drop && cyc == 120) bus.ack = 1'b1;
      if (drop && cyc == 121) bus.ack = 1'b0;
      if (done_cyc < 0) begin
        @(posedge clk);
        cyc++;
      end
    end
    check("done_cycle", done_cyc, NP + 3);
    check("first_we_cycle", first_we, 3);
    check("last_we_cycle", last_we, NP + 2);
    check("rd_addr_sequence", bad_addr, 0);
    check("busy_in_frame", bad_busy, 0);
    check("white_count_hold", bad_hold, 0);
    check("white_count", bus.white_count, exp_wc);
    check("writes_outstanding", exp_q.size(), 0);
    check("busy_in_done", bus.busy, 0);
    check("rd_addr_in_done", bus.rd_addr, 0);
    repeat (drop ? 50 : 3) begin
      @(negedge clk);
      if (bus.done !== 1'b1 || bus.wr_we !== 1'b0) bad_done++;
    end
    check("done_held", bad_done, 0);
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    @(negedge clk);
    check("done_drop_on_ack", bus.done, 0);
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad_rs++;
    end
    check("no_restart_while_ack", bad_rs, 0);
    check("white_count_after_ack", bus.white_count, exp_wc);
    bus.start = 1'b0;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_mid_frame();
    int bad;
    load_frame(3, 7);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.ack    = 1'b0;
    bus.thresh = 4'd7;
    @(posedge clk);
    repeat (150) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_we", bus.wr_we, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    check("rst_white_count", bus.white_count, 0);
    exp_q.delete();
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.wr_we !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("idle_after_reset", bad, 0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.ack    = 1'b0;
    bus.thresh = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_wr_we", bus.wr_we, 0);
    check("reset_rd_addr", bus.rd_addr, 0);
    check("reset_white_count", bus.white_count, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_frame(0, 8, 1'b0);
    run_frame(1, 8, 1'b0);
    run_frame(1, 9, 1'b0);
    run_frame(2, 4, 1'b0);
    run_frame(4, 8, 1'b0);
    run_frame(3, 0, 1'b0);
    run_frame(3, 15, 1'b0);
    run_frame(3, int'($urandom_range(1, 14)), 1'b1);
    for (int k = 0; k < 3; k++) run_frame(3, int'($urandom_range(0, 15)), 1'b0);
    reset_mid_frame();
    run_frame(3, int'($urandom_range(0, 15)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
